// File: rtl/multi_flexcounter_if.sv
// Bus bundle for multi_flexcounter.
//   enable/clear/load/down : per-channel controls, one bit per channel
//   loadValue/maxCount     : per-channel values, channel i at [i*COUNTWIDTH +: COUNTWIDTH]
//   mode                   : [2i+:2] 00 wrap, 01 saturate, 10 one-shot, 11 wrap
//   count/strobe/done      : registered per-channel results
//   anyStrobe              : OR of all strobe bits
interface multi_flexcounter_if #(
  parameter int unsigned COUNTWIDTH = 8,
  parameter int unsigned NUM_CH     = 4
);
  logic [NUM_CH-1:0]            enable;
  logic [NUM_CH-1:0]            clear;
  logic [NUM_CH-1:0]            load;
  logic [NUM_CH*COUNTWIDTH-1:0] loadValue;
  logic [NUM_CH*COUNTWIDTH-1:0] maxCount;
  logic [NUM_CH-1:0]            down;
  logic [2*NUM_CH-1:0]          mode;
  logic [NUM_CH*COUNTWIDTH-1:0] count;
  logic [NUM_CH-1:0]            strobe;
  logic [NUM_CH-1:0]            done;
  logic                         anyStrobe;

  modport master (
    output enable, clear, load, loadValue, maxCount, down, mode,
    input  count, strobe, done, anyStrobe
  );

  modport slave (
    input  enable, clear, load, loadValue, maxCount, down, mode,
    output count, strobe, done, anyStrobe
  );
endinterface

// File: rtl/multi_flexcounter.sv
// NUM_CH independent flex counters sharing one clock and async active-low reset.
// Each channel: clear > load > enable > hold; wrap/saturate/one-shot modes,
// up/down direction, registered terminal strobe and one-shot done flag.
//   clk  : system clock, all state on posedge
//   nRST : asynchronous active-low reset
//   bus  : multi_flexcounter_if slave (controls in, count/strobe/done/anyStrobe out)
module multi_flexcounter #(
  parameter int unsigned COUNTWIDTH = 8,
  parameter int unsigned NUM_CH     = 4
) (
  input  logic                  clk,
  input  logic                  nRST,
  multi_flexcounter_if.slave    bus
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_ALT = 2'b11
  } mode_e;

  typedef struct packed {
    logic [COUNTWIDTH-1:0] cnt;
    logic                  strobe;
    logic                  done;
  } chan_t;

  logic [COUNTWIDTH-1:0] cnt_q [NUM_CH];
  logic [COUNTWIDTH-1:0] cnt_d [NUM_CH];
  logic [NUM_CH-1:0]     strobe_q, strobe_d;
  logic [NUM_CH-1:0]     done_q, done_d;

  function automatic chan_t step_chan(
    input logic [COUNTWIDTH-1:0] cnt,
    input logic                  done,
    input logic                  en,
    input logic                  clr,
    input logic                  ld,
    input logic                  dn,
    input mode_e                 md,
    input logic [COUNTWIDTH-1:0] mx,
    input logic [COUNTWIDTH-1:0] lv
  );
    chan_t                 r;
    logic [COUNTWIDTH-1:0] nxt;
    logic [COUNTWIDTH-1:0] term;
    logic                  wrap;
    r.cnt    = cnt;
    r.strobe = 1'b0;
    r.done   = done;
    wrap     = (md == MODE_WRAP) || (md == MODE_WRAP_ALT);
    term     = dn ? '0 : mx;
    nxt      = cnt;
    if (clr) begin
      r.cnt  = '0;
      r.done = 1'b0;
    end else if (ld) begin
      r.cnt  = lv;
      r.done = 1'b0;
    end else if (en && !done && (mx != '0)) begin
      if (!dn) begin
        // at or beyond the terminal (e.g. maxCount lowered mid-count)
        if (cnt >= mx) nxt = wrap ? COUNTWIDTH'(1) : mx;
        else           nxt = cnt + 1'b1;
      end else begin
        if (cnt == '0)    nxt = wrap ? mx : '0;
        else if (cnt > mx) nxt = mx;
        else               nxt = cnt - 1'b1;
      end
      r.cnt    = nxt;
      // strobe only on arrival at the terminal, never while sitting on it
      r.strobe = (nxt == term) && (cnt != term);
      if (r.strobe && (md == MODE_ONESHOT)) r.done = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    chan_t c;
    c        = '0;
    strobe_d = '0;
    done_d   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      c = step_chan(cnt_q[i], done_q[i], bus.enable[i], bus.clear[i], bus.load[i],
                    bus.down[i], mode_e'(bus.mode[2*i +: 2]),
                    bus.maxCount[i*COUNTWIDTH +: COUNTWIDTH],
                    bus.loadValue[i*COUNTWIDTH +: COUNTWIDTH]);
      cnt_d[i]    = c.cnt;
      strobe_d[i] = c.strobe;
      done_d[i]   = c.done;
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      strobe_q <= '0;
      done_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign bus.count[g*COUNTWIDTH +: COUNTWIDTH] = cnt_q[g];
  end

  assign bus.strobe    = strobe_q;
  assign bus.done      = done_q;
  assign bus.anyStrobe = |strobe_q;

endmodule
